// File: rtl/mii_mac_tx_framer.sv
// MII transmit MAC: AXI-Stream bytes in, preamble/SFD + data + pad + FCS + IFG out as registered nibbles.
// Latency: first mii_en one cycle after tvalid is seen idle; backpressure: tready offered once per byte time.
module mii_mac_tx_framer #(
    parameter int PREAMBLE_BYTES  = 7,
    parameter int IFG_BYTES       = 12,
    parameter bit PAD_ENABLE      = 1'b1,
    parameter int MIN_FRAME_BYTES = 64,
    parameter bit FCS_ENABLE      = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] mii_d,
    output logic       mii_en,
    output logic       mii_er,
    input  logic [7:0] saxis_tdata,
    input  logic       saxis_tvalid,
    output logic       saxis_tready,
    input  logic       saxis_tlast,
    output logic       frame_done,
    output logic       underrun
);

    localparam int          PAD_TARGET = MIN_FRAME_BYTES - (FCS_ENABLE ? 4 : 0);
    localparam logic [10:0] PAD_TGT_W  = 11'(PAD_TARGET);
    localparam logic [5:0]  PRE_LAST   = 6'(2 * PREAMBLE_BYTES - 1);
    // The IDLE cycle that samples the next tvalid is the final gap cycle,
    // so the IFG state itself lasts one cycle less than the full gap.
    localparam logic [5:0]  IFG_LOAD   = 6'(2 * IFG_BYTES - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_ERR, S_DROP, S_IFG
    } state_t;

    state_t      state_q, state_d;
    logic        phase_q, phase_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  hi_q;
    logic        last_q;
    logic [31:0] crc_q;
    logic [10:0] count_q;

    logic [3:0]  d_d;
    logic        en_d, er_d, done_d, urun_d;
    logic        byte_slot, take_byte, end_of_byte, need_pad, pad_byte;
    logic [31:0] fcs_word;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign byte_slot    = (state_q == S_SFD || state_q == S_DATA) && phase_q && !last_q;
    assign saxis_tready = byte_slot || (state_q == S_DROP);
    assign take_byte    = byte_slot && saxis_tvalid;
    assign end_of_byte  = ((state_q == S_DATA && last_q) || state_q == S_PAD) && phase_q;
    assign need_pad     = PAD_ENABLE && (count_q < PAD_TGT_W);
    assign pad_byte     = end_of_byte && need_pad;
    assign fcs_word     = ~crc_q;

    // State register and registered MII/status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= 1'b0;
            cnt_q      <= '0;
            mii_d      <= 4'h0;
            mii_en     <= 1'b0;
            mii_er     <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            cnt_q      <= cnt_d;
            mii_d      <= d_d;
            mii_en     <= en_d;
            mii_er     <= er_d;
            frame_done <= done_d;
            underrun   <= urun_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                phase_d = 1'b0;
                if (saxis_tvalid) begin
                    state_d = S_PRE;
                    cnt_d   = PRE_LAST;
                end
            end
            S_PRE: begin
                if (cnt_q == 6'd0) begin
                    state_d = S_SFD;
                    phase_d = 1'b0;
                end else begin
                    cnt_d   = cnt_q - 6'd1;
                    phase_d = ~phase_q;
                end
            end
            S_SFD, S_DATA, S_PAD: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else if (byte_slot) begin
                    state_d = saxis_tvalid ? S_DATA : S_ERR;
                    phase_d = 1'b0;
                end else begin
                    phase_d = 1'b0;
                    if (need_pad) begin
                        state_d = S_PAD;
                    end else if (FCS_ENABLE) begin
                        state_d = S_FCS;
                        cnt_d   = 6'd0;
                    end else begin
                        state_d = S_IFG;
                        cnt_d   = IFG_LOAD;
                    end
                end
            end
            S_FCS: begin
                phase_d = ~phase_q;
                if (cnt_q[2:0] == 3'd7) begin
                    state_d = S_IFG;
                    cnt_d   = IFG_LOAD;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_ERR: begin
                phase_d = ~phase_q;
                if (phase_q)
                    state_d = S_DROP;
            end
            S_DROP: begin
                phase_d = 1'b0;
                if (saxis_tvalid && saxis_tlast) begin
                    state_d = S_IFG;
                    cnt_d   = IFG_LOAD;
                end
            end
            S_IFG: begin
                phase_d = 1'b0;
                if (cnt_q == 6'd0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q - 6'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: values for the nibble driven in the next cycle
    always_comb begin
        d_d    = 4'h0;
        en_d   = 1'b0;
        er_d   = 1'b0;
        done_d = 1'b0;
        urun_d = byte_slot && !saxis_tvalid;
        case (state_d)
            S_PRE: begin
                en_d = 1'b1;
                d_d  = 4'h5;
            end
            S_SFD: begin
                en_d = 1'b1;
                d_d  = phase_d ? 4'hD : 4'h5;
            end
            S_DATA: begin
                en_d = 1'b1;
                d_d  = phase_d ? hi_q : saxis_tdata[3:0];
                done_d = !FCS_ENABLE && state_q == S_DATA && !phase_q && last_q && !need_pad;
            end
            S_PAD: begin
                en_d   = 1'b1;
                done_d = !FCS_ENABLE && state_q == S_PAD && !phase_q && !need_pad;
            end
            S_FCS: begin
                en_d   = 1'b1;
                d_d    = fcs_word[{cnt_d[2:0], 2'b00} +: 4];
                done_d = (cnt_d[2:0] == 3'd7);
            end
            S_ERR: begin
                en_d = 1'b1;
                er_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Byte datapath: held high nibble, tlast flag, running CRC and byte count
    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q    <= 4'h0;
            last_q  <= 1'b0;
            crc_q   <= 32'hFFFFFFFF;
            count_q <= '0;
        end else if (state_q == S_IDLE && state_d == S_PRE) begin
            last_q  <= 1'b0;
            crc_q   <= 32'hFFFFFFFF;
            count_q <= '0;
        end else if (take_byte || pad_byte) begin
            hi_q    <= take_byte ? saxis_tdata[7:4] : 4'h0;
            crc_q   <= crc_byte(crc_q, take_byte ? saxis_tdata : 8'h00);
            count_q <= (count_q == 11'h7FF) ? count_q : count_q + 11'd1;
            if (take_byte)
                last_q <= saxis_tlast;
        end
    end

endmodule

// File: tb/tb_mii_mac_tx_framer.sv
// Scoreboard bench for mii_mac_tx_framer: three parameter sets, directed frames,
// expected nibbles queued at stimulus time and compared by an independent monitor.
module tb_mii_mac_tx_framer;

    typedef struct packed {
        logic [3:0] d;
        logic       er;
        logic       done;
        logic       ur;
    } nib_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] tdata;
    logic       tvalid, tlast;
    logic [1:0] sel;
    logic [3:0] d [0:2];
    logic [2:0] en, er, rdy, done, ur, tv;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    nib_t exp_q[$];
    int   gap_q[$];
    int   rise_q[$];
    int   acc_q[$];
    logic [7:0] fr[$];
    int   last_acc;
    int   last_en_cyc = 0;
    logic prev_en = 1'b0;
    nib_t got, want;

    always @(posedge clk) cyc <= cyc + 1;

    assign tv = {tvalid && sel == 2'd2, tvalid && sel == 2'd1, tvalid && sel == 2'd0};

    mii_mac_tx_framer #(.PREAMBLE_BYTES(7), .IFG_BYTES(12), .PAD_ENABLE(1'b0),
                        .MIN_FRAME_BYTES(64), .FCS_ENABLE(1'b1)) dut_a (
        .clock(clk), .reset(reset), .mii_d(d[0]), .mii_en(en[0]), .mii_er(er[0]),
        .saxis_tdata(tdata), .saxis_tvalid(tv[0]), .saxis_tready(rdy[0]),
        .saxis_tlast(tlast), .frame_done(done[0]), .underrun(ur[0]));

    mii_mac_tx_framer #(.PREAMBLE_BYTES(7), .IFG_BYTES(12), .PAD_ENABLE(1'b1),
                        .MIN_FRAME_BYTES(64), .FCS_ENABLE(1'b1)) dut_b (
        .clock(clk), .reset(reset), .mii_d(d[1]), .mii_en(en[1]), .mii_er(er[1]),
        .saxis_tdata(tdata), .saxis_tvalid(tv[1]), .saxis_tready(rdy[1]),
        .saxis_tlast(tlast), .frame_done(done[1]), .underrun(ur[1]));

    mii_mac_tx_framer #(.PREAMBLE_BYTES(3), .IFG_BYTES(12), .PAD_ENABLE(1'b1),
                        .MIN_FRAME_BYTES(64), .FCS_ENABLE(1'b0)) dut_c (
        .clock(clk), .reset(reset), .mii_d(d[2]), .mii_en(en[2]), .mii_er(er[2]),
        .saxis_tdata(tdata), .saxis_tvalid(tv[2]), .saxis_tready(rdy[2]),
        .saxis_tlast(tlast), .frame_done(done[2]), .underrun(ur[2]));

    // Monitor: every cycle of the selected DUT, sampled on the falling edge
    always @(negedge clk) begin
        if (en[sel]) begin
            if (!prev_en) begin
                rise_q.push_back(cyc);
                gap_q.push_back(cyc - last_en_cyc - 1);
            end
            last_en_cyc = cyc;
            checks++;
            got = '{d: d[sel], er: er[sel], done: done[sel], ur: ur[sel]};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL extra_nibble got d=%h er=%b done=%b ur=%b want none", got.d, got.er, got.done, got.ur);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL nibble at cycle %0d got d=%h er=%b done=%b ur=%b want d=%h er=%b done=%b ur=%b",
                             cyc, got.d, got.er, got.done, got.ur, want.d, want.er, want.done, want.ur);
                end
            end
        end else begin
            checks++;
            if ({er[sel], done[sel], ur[sel]} !== 3'b000) begin
                errors++;
                $display("FAIL idle_status at cycle %0d got er/done/ur=%b%b%b want 000", cyc, er[sel], done[sel], ur[sel]);
            end
        end
        prev_en = en[sel];
    end

    function automatic logic [31:0] crc_model(input logic [31:0] c_in, input logic [7:0] b_in);
        logic [31:0] c;
        logic [7:0]  b;
        logic        fb;
        c = c_in;
        b = b_in;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[0];
            c  = c >> 1;
            b  = b >> 1;
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    function automatic void push_nib(input logic [3:0] v, input logic e, input logic u);
        nib_t n;
        n = '{d: v, er: e, done: 1'b0, ur: u};
        exp_q.push_back(n);
    endfunction

    function automatic void push_byte(input logic [7:0] b);
        push_nib(b[3:0], 1'b0, 1'b0);
        push_nib(b[7:4], 1'b0, 1'b0);
    endfunction

    // Expected wire image of the frame currently in fr[]
    function automatic void push_exp(input int pb, input bit pad_en, input int min_b, input bit fcs_en,
                                     input int skip, input bit hand, input logic [31:0] hand_fcs);
        logic [31:0] crc;
        logic [31:0] fcs;
        int          n;
        int          target;
        nib_t        t;
        crc = 32'hFFFFFFFF;
        n   = 0;
        for (int i = 0; i < 2 * pb + 1; i++) push_nib(4'h5, 1'b0, 1'b0);
        push_nib(4'hD, 1'b0, 1'b0);
        for (int i = 0; i < fr.size(); i++) begin
            if (i == skip) begin
                push_nib(4'h0, 1'b1, 1'b1);
                push_nib(4'h0, 1'b1, 1'b0);
                return;
            end
            crc = crc_model(crc, fr[i]);
            n++;
            push_byte(fr[i]);
        end
        target = min_b - (fcs_en ? 4 : 0);
        while (pad_en && n < target) begin
            crc = crc_model(crc, 8'h00);
            n++;
            push_byte(8'h00);
        end
        if (fcs_en) begin
            fcs = hand ? hand_fcs : ~crc;
            for (int k = 0; k < 4; k++) push_byte(fcs[8*k +: 8]);
        end
        t = exp_q.pop_back();
        t.done = 1'b1;
        exp_q.push_back(t);
    endfunction

    // Drive fr[]; called on a falling edge. skip >= 0 leaves that byte's tready slot unused.
    task automatic send(input int skip);
        int n;
        for (int i = 0; i < fr.size(); i++) begin
            if (i == skip) begin
                tvalid = 1'b0;
                n = 0;
                while (!rdy[sel] && n < 200) begin @(negedge clk); n++; end
                @(negedge clk);
            end
            tdata  = fr[i];
            tlast  = (i == fr.size() - 1);
            tvalid = 1'b1;
            n = 0;
            while (!rdy[sel] && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) begin
                checks++;
                errors++;
                $display("FAIL tready_timeout byte %0d got no tready want tready", i);
                tvalid = 1'b0;
                return;
            end
            acc_q.push_back(cyc);
            last_acc = cyc;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain remaining=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        repeat (40) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_intervals(input string name);
        int bad;
        bad = 0;
        for (int i = 1; i < acc_q.size(); i++)
            if (acc_q[i] - acc_q[i-1] != 2) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s tready_spacing bad=%0d want 0", name, bad);
        end
        acc_q.delete();
    endtask

    task automatic load_123456789();
        fr.delete();
        for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        tvalid = 1'b0;
        tlast  = 1'b0;
        tdata  = 8'h00;
        sel    = 2'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({d[k], en[k], er[k], rdy[k], done[k], ur[k]} !== 9'd0) begin
                errors++;
                $display("FAIL reset_state dut%0d got d=%h en=%b er=%b rdy=%b done=%b ur=%b want all 0",
                         k, d[k], en[k], er[k], rdy[k], done[k], ur[k]);
            end
        end
        reset = 1'b0;
        @(negedge clk);

        // No padding, FCS of "123456789" is 0xCBF43926
        sel = 2'd0;
        load_123456789();
        push_exp(7, 1'b0, 64, 1'b1, -1, 1'b1, 32'hCBF43926);
        send(-1);
        tvalid = 1'b0;
        drain();

        // Same payload padded to 60 bytes
        sel = 2'd1;
        load_123456789();
        push_exp(7, 1'b1, 64, 1'b1, -1, 1'b0, 32'h0);
        send(-1);
        tvalid = 1'b0;
        drain();

        // Two 64-byte frames back to back, tvalid held
        acc_q.delete();
        fr.delete();
        for (int i = 0; i < 64; i++) fr.push_back(8'(i * 3 + 1));
        push_exp(7, 1'b1, 64, 1'b1, -1, 1'b0, 32'h0);
        send(-1);
        check_intervals("frame1");
        fr.delete();
        for (int i = 0; i < 64; i++) fr.push_back(8'(i ^ 8'hA5));
        push_exp(7, 1'b1, 64, 1'b1, -1, 1'b0, 32'h0);
        send(-1);
        check_intervals("frame2");
        tvalid = 1'b0;
        drain();
        checks++;
        if (gap_q[$] != 24) begin
            errors++;
            $display("FAIL b2b_gap got %0d want 24", gap_q[$]);
        end

        // Underrun at the 10th byte, then a good frame immediately after
        fr.delete();
        for (int i = 0; i < 20; i++) fr.push_back(8'(8'h40 + i));
        push_exp(7, 1'b1, 64, 1'b1, 9, 1'b0, 32'h0);
        send(9);
        begin
            int drop_last;
            drop_last = last_acc;
            load_123456789();
            push_exp(7, 1'b1, 64, 1'b1, -1, 1'b0, 32'h0);
            send(-1);
            tvalid = 1'b0;
            drain();
            checks++;
            if (rise_q[$] - drop_last != 25) begin
                errors++;
                $display("FAIL underrun_ifg got %0d want 25 cycles from tlast to next mii_en", rise_q[$] - drop_last);
            end
        end

        // Reset while the FCS is on the wire
        load_123456789();
        push_exp(7, 1'b1, 64, 1'b1, -1, 1'b0, 32'h0);
        send(-1);
        tvalid = 1'b0;
        begin
            int n;
            n = 0;
            while (exp_q.size() != 8 && n < 400) begin @(posedge clk); n++; end
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        checks++;
        if ({en[1], er[1], rdy[1]} !== 3'b000) begin
            errors++;
            $display("FAIL reset_in_fcs got en=%b er=%b rdy=%b want 000", en[1], er[1], rdy[1]);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        load_123456789();
        push_exp(7, 1'b1, 64, 1'b1, -1, 1'b0, 32'h0);
        send(-1);
        tvalid = 1'b0;
        drain();

        // Short preamble, no FCS, single byte padded to 64
        sel = 2'd2;
        fr.delete();
        fr.push_back(8'hAB);
        push_exp(3, 1'b1, 64, 1'b0, -1, 1'b0, 32'h0);
        send(-1);
        tvalid = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mii_mac_tx_framer.md
Name: mii_mac_tx_framer

Overview:
Parametrised MII transmit MAC for the MII MAC datapath. Takes an 8-bit AXI-Stream frame (destination MAC through payload) and emits a complete Ethernet frame on a 4-bit MII: preamble and SFD, data, optional zero padding, optional CRC-32 FCS, then an enforced inter-frame gap. Adds underrun detection with an MII error signal and per-frame status pulses.

Parameters:
PREAMBLE_BYTES, 7, number of 0x55 bytes before the SFD (1..15)
IFG_BYTES, 12, minimum inter-frame gap in byte times; 2*IFG_BYTES cycles with mii_en=0 (1..31)
PAD_ENABLE, 1, 1 = zero-pad data to MIN_FRAME_BYTES-4 before the FCS
MIN_FRAME_BYTES, 64, minimum frame length including FCS, excluding preamble/SFD
FCS_ENABLE, 1, 1 = append the 4-byte CRC-32; 0 = omit it (PAD_ENABLE then pads to MIN_FRAME_BYTES)

Ports:
clock  in  1  MII TX clock; all logic runs on the rising edge
reset  in  1  synchronous, active-high reset
mii_d  out  4  MII TXD nibble, registered
mii_en  out  1  MII TX_EN, registered
mii_er  out  1  MII TX_ER, registered
saxis_tdata  in  8  frame byte
saxis_tvalid  in  1  byte valid
saxis_tready  out  1  byte accepted when tvalid&&tready
saxis_tlast  in  1  last byte of frame
frame_done  out  1  one-cycle pulse when the last FCS nibble (or last data/pad nibble if FCS_ENABLE=0) is driven
underrun  out  1  one-cycle pulse when an underrun is detected

Behaviour:
- Reset: mii_d=0, mii_en=0, mii_er=0, saxis_tready=0, frame_done=0, underrun=0; state IDLE; CRC=0xFFFFFFFF; byte counter=0. Reset mid-frame takes effect the next cycle: mii_en drops immediately, no IFG is inserted, and the partial frame is abandoned.
- Byte serialisation: every byte takes 2 cycles on MII, low nibble first. A phase bit toggles each cycle while mii_en=1.
- States: IDLE -> PREAMBLE -> SFD -> DATA -> (PAD) -> (FCS) -> IFG -> IDLE, plus DROP.
- IDLE: tready=0. When saxis_tvalid=1 is sampled, go to PREAMBLE. First mii_en=1 appears on the next cycle.
- PREAMBLE: 2*PREAMBLE_BYTES nibbles of 0x5. SFD: nibble 0x5, then 0xD.
- Handshake: saxis_tready=1 only during the cycle in which the high nibble of the SFD or of a data byte is on mii_d, and only if tlast has not yet been accepted in this frame. The accepted byte's low nibble is on mii_d the next cycle. A continuous stream therefore sees tready high every other cycle.
- Underrun: tready=1 in that slot but tvalid=0 while in DATA or SFD. Pulse underrun, drive one byte (2 cycles) with mii_en=1, mii_er=1, mii_d=0, then go to DROP. No FCS, no frame_done.
- DROP: mii_en=0, tready=1, discard bytes until tlast is accepted, then go to IFG. The IFG count starts on the cycle after tlast.
- After the tlast byte:
  - If PAD_ENABLE=1 and byte count < MIN_FRAME_BYTES-4*FCS_ENABLE, go to PAD and emit 0x00 bytes until the count reaches that value.
  - Otherwise go to FCS if FCS_ENABLE=1, else to IFG.
- Byte counter: 11 bits, counts data+pad bytes, saturates at 2047.
- CRC-32 (IEEE 802.3, reflected poly 0xEDB88320, init 0xFFFFFFFF):
  - Updated per byte over data and pad only; preamble/SFD are excluded.
  - FCS = ~CRC, sent as 4 bytes LSB byte first, each byte low nibble first.
  - CRC is reinitialised on entry to PREAMBLE.
- IFG: mii_en=0 for exactly 2*IFG_BYTES cycles, then IDLE. tvalid during IFG is ignored, with tready=0.
- Back-to-back frames: the next frame's first mii_en=1 comes ≥ 2*IFG_BYTES+1 cycles after the last frame nibble.
- Status outputs: frame_done and underrun are mutually exclusive and never asserted for more than one cycle.

Test Plan:
- Payload ASCII "123456789" (9 bytes, tlast on '9'), PAD_ENABLE=0, FCS_ENABLE=1 -> mii_d shows 15×0x5, then 0xD, then data nibbles 1,3,2,3,…,9,3, then FCS nibbles 6,2,9,3,4,F,B,C. frame_done pulses on nibble C. mii_en is high for 16+18+8=42 cycles.
- Same payload with PAD_ENABLE=1 -> 51 bytes of 0x00 follow the '9' (60 data+pad bytes), then a 4-byte FCS matching a software CRC-32 of the padded data. mii_en is high for 16+120+8 cycles.
- Two 64-byte frames presented back-to-back with tvalid held high, IFG_BYTES=12 -> exactly 24 cycles of mii_en=0 between frames; tready high every other cycle during DATA.
- tvalid dropped for one tready slot at data byte 10 -> underrun pulses once, and one byte is sent with mii_er=1. mii_en falls while bytes are drained to tlast, then a 24-cycle IFG follows and frame_done never pulses.
- reset asserted during FCS -> next cycle mii_en=0, mii_er=0, tready=0. A new frame started right after reset shows a fresh preamble and correct FCS.
- PREAMBLE_BYTES=3, FCS_ENABLE=0, PAD_ENABLE=1, MIN_FRAME_BYTES=64, 1-byte frame 0xAB -> 7×0x5, 0xD, then nibbles B,A, then 63 zero bytes. No FCS; frame_done pulses on the final zero nibble.
